// File: rtl/pixel_fetch.sv
// pixel_fetch: turns warped source coordinates into frame-buffer reads and streams the
// returned pixels, in issue order, as an AXI4-Stream video stream with frame/line markers.
module pixel_fetch #(
    parameter int unsigned       H_RES        = 1080,
    parameter int unsigned       V_RES        = 960,
    parameter int unsigned       ADDR_W       = 20,
    parameter int unsigned       DATA_W       = 24,
    parameter int unsigned       READ_LATENCY = 2,
    parameter int unsigned       FIFO_DEPTH   = 16,
    parameter logic [DATA_W-1:0] BLANK        = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       xOut,
    input  logic [11:0]       yOut,
    input  logic              addr_vld,
    output logic              mem_ready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_tdata,
    output logic              pix_tvalid,
    input  logic              pix_tready,
    output logic              pix_tuser,
    output logic              pix_tlast,
    output logic              ovf_err
);

    localparam int unsigned PEND_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned COL_W  = $clog2(H_RES);
    localparam int unsigned ROW_W  = $clog2(V_RES);

    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(FIFO_DEPTH);
    localparam logic [PEND_W-1:0] PEND_RDY  = PEND_W'(FIFO_DEPTH - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_RES - 1);

    // ---------------------------------------------------------------- credit
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              accept;
    logic              pop;
    logic              ovf_q;

    assign accept    = addr_vld && (pending_q != PEND_MAX);
    assign mem_ready = (pending_q < PEND_RDY);

    always_comb begin
        pending_d = pending_q;
        case ({accept, pop})
            2'b10:   pending_d = pending_q + PEND_W'(1);
            2'b01:   pending_d = pending_q - PEND_W'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (addr_vld && (pending_q == PEND_MAX)) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign ovf_err = ovf_q;

    // ---------------------------------------------------------------- stage A
    logic [11:0] a_x_q, a_y_q;
    logic        a_vld_q, a_oob_q;
    logic        in_oob;

    assign in_oob = (32'(xOut) >= H_RES) || (32'(yOut) >= V_RES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_x_q   <= '0;
            a_y_q   <= '0;
            a_vld_q <= 1'b0;
            a_oob_q <= 1'b0;
        end else begin
            a_vld_q <= accept;
            if (accept) begin
                a_x_q   <= xOut;
                a_y_q   <= yOut;
                a_oob_q <= in_oob;
            end
        end
    end

    // ---------------------------------------------------------------- stage B / issue
    logic              b_vld_q, b_oob_q;
    logic              mem_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] lin_addr;

    // Computed modulo 2^ADDR_W, identical to truncating the full-width product.
    assign lin_addr = ADDR_W'(a_y_q) * ADDR_W'(H_RES) + ADDR_W'(a_x_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_vld_q    <= 1'b0;
            b_oob_q    <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            b_vld_q  <= a_vld_q;
            b_oob_q  <= a_oob_q;
            mem_en_q <= a_vld_q && !a_oob_q;
            if (a_vld_q && !a_oob_q) begin
                mem_addr_q <= lin_addr;
            end
        end
    end

    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;

    // ---------------------------------------------------------------- return delay line
    logic [READ_LATENCY-1:0] dl_vld_q, dl_oob_q;
    logic                    push;
    logic [DATA_W-1:0]       push_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_vld_q <= '0;
            dl_oob_q <= '0;
        end else begin
            dl_vld_q[0] <= b_vld_q;
            dl_oob_q[0] <= b_oob_q;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_oob_q[i] <= dl_oob_q[i-1];
            end
        end
    end

    assign push      = dl_vld_q[READ_LATENCY-1];
    assign push_data = dl_oob_q[READ_LATENCY-1] ? BLANK : mem_rdata;

    // ---------------------------------------------------------------- output FIFO
    // Registered head word in front of a circular store; an empty store lets a push
    // bypass straight into the head so first-word latency is one cycle.
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              head_vld_q;
    logic [DATA_W-1:0] head_q;
    logic              head_load, load_from_mem, bypass, mem_wr;

    assign pop           = head_vld_q && pix_tready;
    assign head_load     = !head_vld_q || pop;
    assign load_from_mem = head_load && (cnt_q != '0);
    assign bypass        = head_load && (cnt_q == '0) && push;
    assign mem_wr        = push && !bypass;

    always_comb begin
        cnt_d = cnt_q;
        case ({mem_wr, load_from_mem})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (mem_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (load_from_mem) begin
                head_q     <= fifo_mem[rd_ptr_q];
                head_vld_q <= 1'b1;
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            end else if (bypass) begin
                head_q     <= push_data;
                head_vld_q <= 1'b1;
            end else if (pop) begin
                head_vld_q <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- raster position
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pop) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    assign pix_tvalid = head_vld_q;
    assign pix_tdata  = head_q;
    assign pix_tuser  = head_vld_q && (col_q == '0) && (row_q == '0);
    assign pix_tlast  = head_vld_q && (col_q == COL_LAST);

endmodule

// File: tb/tb_pixel_fetch.sv
// Scoreboard bench for pixel_fetch: stimulus pushes expected reads and pixels into queues,
// independent monitors pop and compare whenever the DUT issues a read or a pixel handshake.
module tb_pixel_fetch;

    localparam int H  = 1080;
    localparam int V  = 960;
    localparam int RL = 2;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] xOut = '0;
    logic [11:0] yOut = '0;
    logic        addr_vld = 1'b0;
    logic        mem_ready;
    logic        mem_en;
    logic [19:0] mem_addr;
    logic [23:0] mem_rdata;
    logic [23:0] pix_tdata;
    logic        pix_tvalid;
    logic        pix_tready = 1'b1;
    logic        pix_tuser;
    logic        pix_tlast;
    logic        ovf_err;

    pixel_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .xOut       (xOut),
        .yOut       (yOut),
        .addr_vld   (addr_vld),
        .mem_ready  (mem_ready),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .pix_tdata  (pix_tdata),
        .pix_tvalid (pix_tvalid),
        .pix_tready (pix_tready),
        .pix_tuser  (pix_tuser),
        .pix_tlast  (pix_tlast),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_mem_en = 0;
    int n_pop    = 0;
    int n_tlast  = 0;
    int n_tuser  = 0;
    int ecol     = 0;
    int erow     = 0;

    pix_t        exp_q[$];
    logic [19:0] addr_q[$];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [23:0] mem_func(input logic [19:0] a);
        return (a == 20'd2165) ? 24'hABCDEF : {4'h5, a};
    endfunction

    // Synchronous memory model with READ_LATENCY register stages.
    logic [23:0] rd_pipe [RL];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_en ? mem_func(mem_addr) : 24'hEEEEEE;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    task automatic push_pix(input logic [23:0] d);
        pix_t p;
        p.d = d;
        p.u = (ecol == 0 && erow == 0);
        p.l = (ecol == H - 1);
        exp_q.push_back(p);
        if (ecol == H - 1) begin
            ecol = 0;
            erow = (erow == V - 1) ? 0 : erow + 1;
        end else begin
            ecol++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read-address monitor.
    logic [19:0] mon_a;
    always @(negedge clk) begin
        if (reset && mem_en) begin
            n_mem_en++;
            if (addr_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read: got addr 0x%0h, expected no read at %0t",
                         mem_addr, $time);
            end else begin
                mon_a = addr_q.pop_front();
                check_eq("mem_addr", 32'(mem_addr), 32'(mon_a));
            end
        end
    end

    // Pixel monitor: handshake comparison plus hold-while-stalled check.
    pix_t        mon_p;
    logic        stalled = 1'b0;
    logic [25:0] hold_v;
    always @(negedge clk) begin
        if (!reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check_eq("stall_hold", 32'({pix_tvalid, pix_tuser, pix_tlast, pix_tdata}),
                         32'({1'b1, hold_v}));
            end
            if (pix_tvalid && pix_tready) begin
                n_pop++;
                if (pix_tlast) n_tlast++;
                if (pix_tuser) n_tuser++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pixel: got 0x%0h, expected no pixel at %0t",
                             pix_tdata, $time);
                end else begin
                    mon_p = exp_q.pop_front();
                    check_eq("pixel", 32'({pix_tuser, pix_tlast, pix_tdata}),
                             32'({mon_p.u, mon_p.l, mon_p.d}));
                end
            end
            stalled = pix_tvalid && !pix_tready;
            hold_v  = {pix_tuser, pix_tlast, pix_tdata};
        end
    end

    // Upstream model: launches a coordinate one cycle after seeing mem_ready high.
    task automatic stream(input int n, input int max_cyc, input int x0, input int y0,
                          input int rmode, output int sent);
        int x;
        int y;
        int a;
        bit r;
        x = x0;
        y = y0;
        sent = 0;
        r = mem_ready;
        for (int c = 0; c < max_cyc && sent < n; c++) begin
            if (r) begin
                xOut = 12'(x);
                yOut = 12'(y);
                addr_vld = 1'b1;
                a = y * H + x;
                addr_q.push_back(20'(a));
                push_pix(mem_func(20'(a)));
                sent++;
                if (x == H - 1) begin
                    x = 0;
                    y++;
                end else begin
                    x++;
                end
            end else begin
                addr_vld = 1'b0;
            end
            pix_tready = (rmode == 0) ? 1'b1 :
                         (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
            @(negedge clk);
            r = mem_ready;
            step();
        end
        addr_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        pix_tready = 1'b1;
        while (exp_q.size() != 0 && c < 5000) begin
            step();
            c++;
        end
        check_eq(name, 32'(exp_q.size()), 32'd0);
        repeat (2) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int en0;
        int pop0;
        int tl0;
        int tu0;

        #3 reset = 1'b0;
        repeat (2) step();
        check_eq("rst_mem_ready", 32'(mem_ready), 32'd1);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_tvalid", 32'(pix_tvalid), 32'd0);
        check_eq("rst_tdata", 32'(pix_tdata), 32'd0);
        check_eq("rst_tuser_tlast", 32'({pix_tuser, pix_tlast}), 32'd0);
        check_eq("rst_ovf", 32'(ovf_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Single pixel (5,2) -> addr 2165, latency to mem_en 2, to pix_tvalid 5.
        xOut = 12'd5;
        yOut = 12'd2;
        addr_vld = 1'b1;
        addr_q.push_back(20'd2165);
        push_pix(24'hABCDEF);
        step();
        addr_vld = 1'b0;
        @(negedge clk);
        check_eq("lat_c1_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        check_eq("lat_c2_mem_en", 32'(mem_en), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("lat_c4_tvalid", 32'(pix_tvalid), 32'd0);
        @(negedge clk);
        check_eq("lat_c5_tvalid", 32'(pix_tvalid), 32'd1);
        check_eq("lat_c5_tuser", 32'(pix_tuser), 32'd1);
        @(negedge clk);
        check_eq("lat_c6_tvalid", 32'(pix_tvalid), 32'd0);
        step();

        // Out-of-range in the middle: data(0), BLANK, data(1), two reads only.
        en0 = n_mem_en;
        xOut = 12'd0;    yOut = 12'd0; addr_vld = 1'b1;
        addr_q.push_back(20'd0); push_pix(24'h500000);
        step();
        xOut = 12'd1100; yOut = 12'd0;
        push_pix(24'h000000);
        step();
        xOut = 12'd1;    yOut = 12'd0;
        addr_q.push_back(20'd1); push_pix(24'h500001);
        step();
        addr_vld = 1'b0;
        drain("oob_drain");
        check_eq("oob_read_count", 32'(n_mem_en - en0), 32'd2);

        // Back-pressure: sink stalled, upstream honours mem_ready with a one-cycle skid.
        pix_tready = 1'b0;
        stream(30, 30, 0, 3, 2, sent);
        check_eq("bp_accepted", 32'(sent), 32'd16);
        check_eq("bp_mem_ready_low", 32'(mem_ready), 32'd0);
        repeat (8) step();
        check_eq("bp_tvalid_held", 32'(pix_tvalid), 32'd1);
        check_eq("bp_no_ovf", 32'(ovf_err), 32'd0);
        pop0 = n_pop;
        pix_tready = 1'b1;
        repeat (16) @(negedge clk);
        #1;
        check_eq("bp_throughput", 32'(n_pop - pop0), 32'd16);
        drain("bp_drain");
        check_eq("bp_mem_ready_back", 32'(mem_ready), 32'd1);

        // Overflow: 17 forced coordinates into a stalled sink; the 17th is dropped.
        en0 = n_mem_en;
        pix_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            xOut = 12'(i);
            yOut = 12'd4;
            addr_vld = 1'b1;
            if (i < 16) begin
                addr_q.push_back(20'(4 * H + i));
                push_pix(mem_func(20'(4 * H + i)));
            end
            step();
        end
        addr_vld = 1'b0;
        @(negedge clk);
        check_eq("ovf_set", 32'(ovf_err), 32'd1);
        check_eq("ovf_mem_ready", 32'(mem_ready), 32'd0);
        repeat (8) step();
        drain("ovf_drain");
        check_eq("ovf_sticky", 32'(ovf_err), 32'd1);
        check_eq("ovf_read_count", 32'(n_mem_en - en0), 32'd16);

        // Reset mid-line with 8 entries buffered at column 300.
        stream(264, 2000, 0, 10, 0, sent);
        drain("pre_reset_drain");
        check_eq("pre_reset_col", 32'(ecol), 32'd300);
        pix_tready = 1'b0;
        stream(8, 8, 300, 10, 2, sent);
        repeat (10) step();
        check_eq("pre_reset_tvalid", 32'(pix_tvalid), 32'd1);
        check_eq("pre_reset_tuser", 32'(pix_tuser), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_tvalid", 32'(pix_tvalid), 32'd0);
        check_eq("mid_rst_tdata", 32'(pix_tdata), 32'd0);
        check_eq("mid_rst_ovf", 32'(ovf_err), 32'd0);
        check_eq("mid_rst_mem_ready", 32'(mem_ready), 32'd1);
        check_eq("mid_rst_mem", 32'({mem_en, mem_addr}), 32'd0);
        exp_q.delete();
        addr_q.delete();
        ecol = 0;
        erow = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Two full raster lines with a randomly stalling sink.
        en0 = n_mem_en;
        tl0 = n_tlast;
        tu0 = n_tuser;
        stream(2 * H, 8000, 0, 0, 1, sent);
        check_eq("frame_sent", 32'(sent), 32'(2 * H));
        drain("frame_drain");
        check_eq("frame_reads", 32'(n_mem_en - en0), 32'(2 * H));
        check_eq("frame_tlast_count", 32'(n_tlast - tl0), 32'd2);
        check_eq("frame_tuser_count", 32'(n_tuser - tu0), 32'd1);
        check_eq("reads_all_seen", 32'(addr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_fetch.md
# pixel_fetch

Consumes the warped source coordinates (`xOut`/`yOut`/`addr_vld`) produced by the barrel-distortion math stage, converts each into a linear frame-buffer read address, and issues synchronous-memory reads. It re-orders nothing: each returned pixel, or a blank substitute for an out-of-range coordinate, is buffered in a small FIFO and emitted as an AXI4-Stream video stream in raster order. It back-pressures the math stage through `mem_ready` using a credit count that covers the upstream one-cycle handshake skid.

## Interface
- `H_RES`, 1080, pixels per line.
- `V_RES`, 960, lines per frame.
- `ADDR_W`, 20, frame-buffer address width.
- `DATA_W`, 24, pixel width.
- `READ_LATENCY`, 2, cycles from `mem_en` to valid `mem_rdata`.
- `FIFO_DEPTH`, 16, output FIFO entries (power of two, ≥4).
- `BLANK`, 0, pixel value substituted for out-of-range coordinates.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `xOut`  in  12  source column, unsigned.
- `yOut`  in  12  source row, unsigned.
- `addr_vld`  in  1  coordinate valid; always accepted.
- `mem_ready`  out  1  credit available for upstream.
- `mem_en`  out  1  frame-buffer read enable.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rdata`  in  DATA_W  read data.
- `pix_tdata`  out  DATA_W  output pixel.
- `pix_tvalid`  out  1  output valid.
- `pix_tready`  in  1  sink ready.
- `pix_tuser`  out  1  first pixel of the frame.
- `pix_tlast`  out  1  last pixel of the line.
- `ovf_err`  out  1  sticky overflow flag.

## Operation
- Stage A (register): latch `x`, `y`, `vld=addr_vld`, and `oob = (x >= H_RES) || (y >= V_RES)`.
- Stage B (register): `addr = y*H_RES + x`, truncated to ADDR_W. Carry `vld`, `oob`.
- Issue: `mem_en = vld & ~oob`, `mem_addr = addr` (registered). Out-of-range entries issue no read but occupy their slot.
- Return delay line, READ_LATENCY deep, carries `vld` and `oob`. At the tap, a valid entry writes `oob ? BLANK : mem_rdata` into the FIFO. Ordering is strictly preserved.
- Credit counter `pending` (0..FIFO_DEPTH) counts entries accepted at Stage A and not yet popped.
  - +1 on `addr_vld`.
  - −1 on `pix_tvalid & pix_tready`.
  - Both in the same cycle leave it unchanged.
- `mem_ready = (pending < FIFO_DEPTH-1)`, combinational from the register. This leaves one slot for the `addr_vld` that upstream launches after its last `mem_ready` sample.
- On `addr_vld` with `pending == FIFO_DEPTH`: drop the entry, leave `pending` unchanged, set `ovf_err` (cleared only by reset).
- Output counters `col` (0..H_RES-1) and `row` (0..V_RES-1) advance on each pop.
  - `col` wraps to 0 and increments `row`. `row` wraps to 0 after V_RES-1.
  - `pix_tuser = (col==0 && row==0)`.
  - `pix_tlast = (col == H_RES-1)`.
- FIFO is first-word-fall-through with a registered head. `pix_tdata`/`pix_tuser`/`pix_tlast` hold stable while `pix_tvalid & ~pix_tready`.

## Timing
- Reset values (asynchronous):
  - `mem_en`, `pix_tvalid`, `pix_tuser`, `pix_tlast`, `ovf_err` = 0.
  - `mem_addr`, `pix_tdata` = 0.
  - `pending`, `col`, `row` = 0; FIFO empty; all stage/delay valids = 0.
  - `mem_ready` reads 1 whenever `pending` = 0, including during reset.
- Latency: `addr_vld` in cycle 0 → `mem_en` in cycle 2 → `mem_rdata` captured at end of cycle 2+READ_LATENCY → `pix_tvalid` in cycle 3+READ_LATENCY (5 at default), given an empty FIFO.
- Throughput: one pixel per cycle sustained when `pix_tready` = 1.
- The FIFO never overflows: `pending` bounds in-flight plus stored entries, and the delay line has no stall.
- Reset mid-operation discards in-flight reads and FIFO contents. The next popped pixel carries `pix_tuser` = 1.
- Simultaneous FIFO push and pop at full or empty is legal and keeps occupancy constant.

## Test plan
- Single pixel: `xOut`=5, `yOut`=2, `addr_vld` cycle 0 → `mem_en`=1 with `mem_addr`=2165 in cycle 2; memory model returns 0xABCDEF → `pix_tdata`=0xABCDEF, `pix_tvalid` in cycle 5, `pix_tuser`=1.
- Out-of-range: sequence (0,0), (1100,0), (1,0) → only two `mem_en` pulses; output order is data(0), BLANK, data(1).
- Back-pressure: `pix_tready`=0 with `addr_vld` driven by an upstream model obeying `mem_ready` → `mem_ready` falls when `pending`=15; exactly 16 entries accepted; `ovf_err`=0. Then `pix_tready`=1 → 16 pixels in order, one per cycle.
- Full frame: 1080×960 raster → `pix_tlast` on every 1080th pixel, `pix_tuser` only on pixels 0 and 1,036,800 (start of frame 2), 1,036,800 `mem_en` pulses.
- Overflow: force `addr_vld` with `pending`=16 → `ovf_err`=1 and stays set; `pending` stays 16; dropped pixel never appears.
- Reset mid-frame: assert `reset`=0 with 8 FIFO entries at col 300 → all outputs at reset values immediately; after release, first pixel has `pix_tuser`=1 and col/row = 0.
